// File: rtl/tdm_demux_1in_4out.sv
// Receive side of a 4-channel TDM link.
// Locks to frame sync and deserialises the MSB-first bit stream into four W-bit channel words.

module tdm_chan_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module tdm_demux_1in_4out #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_en,
    input  logic         din,
    input  logic         fsync,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic [3:0]   ch_valid,
    output logic         frame_done,
    output logic         sync_err,
    output logic         locked,
    output logic [1:0]   slot
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic {HUNT, RECV} state_t;

    state_t              state;
    logic [W-2:0]        sr;
    logic [CW-1:0]       bit_cnt;
    logic [W-1:0]        word;
    logic                at_sync;
    logic                last_bit;
    logic                in_frame;
    logic                wr;
    logic [3:0][W-1:0]   outq;
    logic [3:0]          we;

    assign word     = {sr, din};
    assign at_sync  = (bit_cnt == '0) && (slot == 2'd0);
    assign last_bit = (bit_cnt == CW'(W - 1));
    // A bit continues the current frame only if fsync appears exactly where it is expected.
    assign in_frame = (state == RECV) && (at_sync ? fsync : !fsync);
    assign wr       = bit_en && in_frame && last_bit;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_ch
            assign we[g] = wr && (slot == 2'(g));
            tdm_chan_reg #(.W(W)) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (we[g]),
                .d     (word),
                .q     (outq[g])
            );
        end
    endgenerate

    assign out0 = outq[0];
    assign out1 = outq[1];
    assign out2 = outq[2];
    assign out3 = outq[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            sr         <= '0;
            bit_cnt    <= '0;
            slot       <= 2'd0;
            locked     <= 1'b0;
            ch_valid   <= 4'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            ch_valid   <= 4'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (bit_en) begin
                case (state)
                    HUNT: begin
                        if (fsync) begin
                            state   <= RECV;
                            locked  <= 1'b1;
                            sr      <= (W-1)'(din);
                            bit_cnt <= CW'(1);
                            slot    <= 2'd0;
                        end
                    end
                    RECV: begin
                        if (at_sync && !fsync) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                        end else if (!at_sync && fsync) begin
                            // Early marker: drop the partial frame and restart slot 0 on this bit.
                            sync_err <= 1'b1;
                            sr       <= (W-1)'(din);
                            bit_cnt  <= CW'(1);
                            slot     <= 2'd0;
                        end else if (last_bit) begin
                            ch_valid   <= we;
                            frame_done <= (slot == 2'd3);
                            bit_cnt    <= '0;
                            slot       <= slot + 2'd1;
                            sr         <= word[W-2:0];
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sr      <= word[W-2:0];
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_1in_4out.sv
// Bench for tdm_demux_1in_4out: a table-driven nominal frame, hand-written corner sequences,
// and random traffic, all checked against a frame-position model of the receiver.
module tb_tdm_demux_1in_4out;
    localparam int W  = 8;
    localparam int FB = 4 * W;

    logic clk = 0, rst_n = 0, bit_en = 0, din = 0, fsync = 0;
    logic [W-1:0] out0, out1, out2, out3;
    logic [3:0] ch_valid;
    logic frame_done, sync_err, locked;
    logic [1:0] slot;

    tdm_demux_1in_4out #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .din(din), .fsync(fsync),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .ch_valid(ch_valid), .frame_done(frame_done), .sync_err(sync_err),
        .locked(locked), .slot(slot)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Reference model: frame position counter, word accumulator, per-channel results
    bit     m_locked;
    int     m_pos;
    int     m_acc;
    int     m_out[4];
    bit [3:0] m_cv;
    bit     m_fd, m_err;

    function automatic void m_reset();
        m_locked = 0; m_pos = 0; m_acc = 0; m_cv = 0; m_fd = 0; m_err = 0;
        for (int i = 0; i < 4; i++) m_out[i] = 0;
    endfunction

    function automatic void m_bit(input bit en, input bit d, input bit fs);
        m_cv = 0; m_fd = 0; m_err = 0;
        if (!en) return;
        if (!m_locked) begin
            if (fs) begin m_locked = 1; m_pos = 1; m_acc = d; end
        end else if (m_pos == 0 && !fs) begin
            m_err = 1; m_locked = 0;
        end else if (m_pos != 0 && fs) begin
            m_err = 1; m_pos = 1; m_acc = d;
        end else begin
            m_acc = ((m_acc << 1) | d) & ((1 << W) - 1);
            if (m_pos % W == W - 1) begin
                m_out[m_pos / W] = m_acc;
                m_cv[m_pos / W]  = 1'b1;
                m_fd = (m_pos / W == 3);
            end
            m_pos = (m_pos + 1) % FB;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        logic [63:0] a, e;
        a = {out3, out2, out1, out0, ch_valid, frame_done, sync_err, locked, slot};
        e = {m_out[3][W-1:0], m_out[2][W-1:0], m_out[1][W-1:0], m_out[0][W-1:0],
             m_cv, m_fd, m_err, m_locked, m_locked ? 2'(m_pos / W) : 2'd0};
        check(name, a, e);
    endtask

    task automatic step(input bit en, input bit d, input bit fs, input string name);
        bit_en = en; din = d; fsync = fs;
        @(posedge clk); #1;
        m_bit(en, d, fs);
        check_model(name);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit first_fs, input int gap);
        for (int b = W - 1; b >= 0; b--) begin
            for (int g = 0; g < gap; g++) step(0, 1'($urandom), 1'($urandom), "gap");
            step(1, w[b], (b == W - 1) && first_fs, "bit");
        end
    endtask

    typedef struct {
        logic       din, fsync;
        logic [3:0] cv;
        logic       fd;
        logic [1:0] slot;
    } vec_t;
    vec_t vec[FB];
    logic [W-1:0] words[4];

    initial begin
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F; words[3] = 8'hF0;
        for (int i = 0; i < FB; i++) begin
            vec[i].din   = words[i / W][W - 1 - i % W];
            vec[i].fsync = (i == 0);
            vec[i].cv    = (i % W == W - 1) ? 4'(1 << (i / W)) : 4'b0;
            vec[i].fd    = (i == FB - 1);
            vec[i].slot  = 2'(((i + 1) / W) % 4);
        end
        m_reset();

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            bit_en = 1'($urandom); din = 1'($urandom); fsync = 1'($urandom);
            @(posedge clk); #1;
            check("reset", {out3, out2, out1, out0, ch_valid, frame_done, sync_err, locked, slot}, 64'd0);
        end
        rst_n = 1;
        step(1, 1, 0, "hunt_nofs");
        step(0, 1, 1, "hunt_noen");
        check("hunt_locked", locked, 0);

        // Nominal frame from table
        for (int i = 0; i < FB; i++) begin
            step(1, vec[i].din, vec[i].fsync, "nominal");
            check("tbl_cv", {ch_valid, frame_done, sync_err, slot},
                  {vec[i].cv, vec[i].fd, 1'b0, vec[i].slot});
        end
        check("tbl_words", {out0, out1, out2, out3}, {8'hA5, 8'h3C, 8'h0F, 8'hF0});

        // Throttled frame: bit_en every third cycle
        for (int k = 0; k < 4; k++) send_word(words[k], k == 0, 2);
        check("throttle_words", {out0, out1, out2, out3}, {8'hA5, 8'h3C, 8'h0F, 8'hF0});

        // Missing sync on next frame's first bit
        step(1, 1, 0, "miss_sync");
        check("miss_err", {sync_err, locked}, 2'b10);
        for (int i = 0; i < 12; i++) step(1, 1'($urandom), 0, "hunt_idle");
        check("miss_hold", {out0, out1, out2, out3}, {8'hA5, 8'h3C, 8'h0F, 8'hF0});

        // Early sync at slot 1 bit 5, then 0x55 lands in slot 0
        send_word(8'h11, 1, 0);
        for (int b = 7; b > 2; b--) step(1, b[0], 0, "early_pre");
        step(1, 0, 1, "early_fs");
        check("early_err", {sync_err, ch_valid, locked}, 6'b1_0000_1);
        for (int b = 6; b >= 0; b--) step(1, b[0] ? 1'b0 : 1'b1, 0, "early_55");
        check("early_out", {out0, out1, ch_valid}, {8'h55, 8'h3C, 4'b0001});

        // Reset mid-frame at bit 20
        send_word(8'h12, 1, 0);
        send_word(8'h34, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, "pre_rst");
        #2 rst_n = 0; #1;
        check("async_rst", {out3, out2, out1, out0, ch_valid, frame_done, sync_err, locked, slot}, 64'd0);
        #1 rst_n = 1;
        m_reset();
        step(1, 1, 0, "post_rst");
        check("relock_wait", locked, 0);

        // Random traffic, mostly well-framed
        for (int i = 0; i < 3000; i++) begin
            bit fs_ok, fs;
            fs_ok = m_locked ? (m_pos == 0) : 1'b1;
            fs = ($urandom_range(0, 49) == 0) ? !fs_ok : fs_ok;
            step($urandom_range(0, 3) != 0, 1'($urandom), fs, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
